// File: rtl/pim_output_packer.sv
// pim_output_packer
//   Packs per-lane PIM encoder results into 32-bit words and buffers them in a
//   small first-word-fall-through FIFO drained through a valid/ready pop port.
//   PARALLEL mode packs four 7-bit lanes into one word each capture. RBR mode
//   packs four 4-bit lanes into a half-word and joins two captures per word.
//   A lone pending RBR half can be forced out with zero padding.
//
// Ports
//   clk_i             clock, all state on rising edge
//   rst_i             synchronous active-high reset
//   pim_mode_i        3'b101 PARALLEL, 3'b110 RBR, anything else idle
//   enc_valid_i       encoder_output_i valid this cycle
//   encoder_output_i  four 7-bit lane results, lane 0 lands in the low bits
//   flush_i           force out a pending RBR low half
//   rd_valid_o        FIFO non-empty
//   rd_ready_i        consumer pops head when rd_valid_o && rd_ready_i
//   rd_data_o         head word, 0 when empty
//   count_o           words stored
//   half_pend_o       RBR packer holds a stored low half
//   overflow_o        sticky, a word was dropped on a full FIFO
//
// Packer states
//   state      | meaning
//   HALF_EMPTY | no RBR half stored
//   HALF_FULL  | low half held in half_q, waiting for the high half or a flush

module pim_output_packer #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       pim_mode_i,
  input  logic             enc_valid_i,
  input  logic [6:0]       encoder_output_i [0:3],
  input  logic             flush_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [31:0]      rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             half_pend_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [2:0] MODE_PAR = 3'b101;
  localparam logic [2:0] MODE_RBR = 3'b110;

  typedef enum logic {HALF_EMPTY = 1'b0, HALF_FULL = 1'b1} pack_state_e;

  pack_state_e      state_q, state_d;
  logic [15:0]      half_q, half_d;
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic        par_cap, rbr_cap;
  logic [31:0] par_word;
  logic [15:0] rbr_half;
  logic        push, pop, push_ok;
  logic [31:0] push_data;

  assign par_cap  = enc_valid_i && (pim_mode_i == MODE_PAR);
  assign rbr_cap  = enc_valid_i && (pim_mode_i == MODE_RBR);
  assign par_word = {4'b0, encoder_output_i[3], encoder_output_i[2],
                     encoder_output_i[1], encoder_output_i[0]};
  assign rbr_half = {encoder_output_i[3][3:0], encoder_output_i[2][3:0],
                     encoder_output_i[1][3:0], encoder_output_i[0][3:0]};

  // Packer next state and the single push request of this cycle.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    push      = 1'b0;
    push_data = '0;
    if (par_cap) begin
      push      = 1'b1;
      push_data = par_word;
    end
    if (rbr_cap) begin
      if (state_q == HALF_EMPTY) begin
        half_d  = rbr_half;
        state_d = HALF_FULL;
      end else begin
        push      = 1'b1;
        push_data = {rbr_half, half_q};
        state_d   = HALF_EMPTY;
      end
    end else if ((state_q == HALF_FULL) && (flush_i || (pim_mode_i != MODE_RBR))
                 && !par_cap) begin
      // A PARALLEL capture owns the push slot; the flush waits a cycle.
      push      = 1'b1;
      push_data = {16'h0, half_q};
      state_d   = HALF_EMPTY;
    end
  end

  assign pop     = (count_q != '0) && rd_ready_i;
  assign push_ok = push && ((count_q < CNT_W'(DEPTH)) || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !push_ok) overflow_d = 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HALF_EMPTY;
      half_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_valid_o  = (count_q != '0);
  assign rd_data_o   = rd_valid_o ? mem_q[rd_ptr_q] : 32'h0;
  assign count_o     = count_q;
  assign half_pend_o = (state_q == HALF_FULL);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_pim_output_packer.sv
module tb_pim_output_packer;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [2:0]       pim_mode_i;
  logic             enc_valid_i;
  logic [6:0]       encoder_output_i [0:3];
  logic             flush_i;
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic [31:0]      rd_data_o;
  logic [CNT_W-1:0] count_o;
  logic             half_pend_o;
  logic             overflow_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_pend;
  logic [15:0] m_stored;
  bit          m_ovf;

  pim_output_packer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pim_mode_i(pim_mode_i),
    .enc_valid_i(enc_valid_i), .encoder_output_i(encoder_output_i),
    .flush_i(flush_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o), .count_o(count_o), .half_pend_o(half_pend_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count_o), 32'(mq.size()));
    check({tag, ".valid"}, 32'(rd_valid_o), 32'(mq.size() != 0));
    check({tag, ".data"}, rd_data_o, (mq.size() != 0) ? mq[0] : 32'h0);
    check({tag, ".pend"}, 32'(half_pend_o), 32'(m_pend));
    check({tag, ".ovf"}, 32'(overflow_o), 32'(m_ovf));
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enc_valid_i = 1'b1; pim_mode_i = 3'b101; flush_i = 1'b1;
    rd_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; enc_valid_i = 1'b0; pim_mode_i = 3'b000; flush_i = 1'b0;
    rd_ready_i = 1'b0;
    mq.delete(); m_pend = 0; m_stored = 16'h0; m_ovf = 0;
  endtask

  // One clock: drive inputs, predict from the behavioural rules, compare.
  task automatic step(input string tag, input logic [2:0] mode, input bit vld,
                      input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3,
                      input bit fl, input bit rdy);
    logic [31:0] w;
    bit          has_push;
    bit          par, rbr;
    logic [15:0] h;
    pim_mode_i = mode; enc_valid_i = vld; flush_i = fl; rd_ready_i = rdy;
    encoder_output_i[0] = e0; encoder_output_i[1] = e1;
    encoder_output_i[2] = e2; encoder_output_i[3] = e3;
    par = vld && (mode == 3'b101);
    rbr = vld && (mode == 3'b110);
    has_push = 0; w = 32'h0;
    h = {e3[3:0], e2[3:0], e1[3:0], e0[3:0]};
    if (par) begin
      w = {4'b0, e3, e2, e1, e0};
      has_push = 1;
    end
    if (rbr) begin
      if (m_pend) begin
        w = {h, m_stored}; has_push = 1; m_pend = 0;
      end else begin
        m_stored = h; m_pend = 1;
      end
    end else if (m_pend && (fl || mode != 3'b110) && !par) begin
      w = {16'h0, m_stored}; has_push = 1; m_pend = 0;
    end
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (has_push) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1;
    end
    @(posedge clk_i); #1;
    check_all(tag);
  endtask

  initial begin
    rst_i = 1'b0; pim_mode_i = 3'b000; enc_valid_i = 1'b0; flush_i = 1'b0;
    rd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) encoder_output_i[i] = 7'h0;
    do_reset();
    check_all("reset");

    // 1. PARALLEL word layout
    step("par1", 3'b101, 1, 7'h01, 7'h02, 7'h03, 7'h04, 0, 0);
    check("par1.word", rd_data_o, 32'h0080_C101);
    step("par1.pop", 3'b000, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 1);

    // 2. RBR pair; bits [6:4] must be ignored
    step("rbr.lo", 3'b110, 1, 7'h71, 7'h02, 7'h03, 7'h04, 0, 0);
    check("rbr.lo.pend", 32'(half_pend_o), 32'h1);
    step("rbr.hi", 3'b110, 1, 7'h05, 7'h36, 7'h07, 7'h08, 0, 0);
    check("rbr.hi.word", rd_data_o, 32'h8765_4321);
    step("rbr.pop", 3'b110, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 1);

    // 3. Flush by flush_i, then by mode change
    step("fl.lo", 3'b110, 1, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 0, 0);
    step("fl.idle", 3'b110, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 0);
    step("fl.flush", 3'b110, 0, 7'h0, 7'h0, 7'h0, 7'h0, 1, 0);
    check("fl.word", rd_data_o, 32'h0000_DCBA);
    step("fl.pop", 3'b110, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 1);
    step("mc.lo", 3'b110, 1, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 0, 0);
    step("mc.mode", 3'b000, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 0);
    check("mc.word", rd_data_o, 32'h0000_DCBA);
    step("mc.pop", 3'b000, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 1);

    // Pending half with a PARALLEL capture: parallel word first, flush next cycle
    step("pf.lo", 3'b110, 1, 7'h01, 7'h01, 7'h01, 7'h01, 0, 0);
    step("pf.par", 3'b101, 1, 7'h7F, 7'h00, 7'h00, 7'h00, 1, 0);
    step("pf.flush", 3'b000, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 0);
    do_reset();

    // 4. Overflow, then pop+push at full
    for (int i = 1; i <= 9; i++)
      step("ovf.fill", 3'b101, 1, 7'(i), 7'h0, 7'h0, 7'h0, 0, 0);
    check("ovf.head", rd_data_o, 32'h0000_0001);
    check("ovf.flag", 32'(overflow_o), 32'h1);
    step("ovf.pp", 3'b101, 1, 7'h55, 7'h0, 7'h0, 7'h0, 0, 1);
    check("ovf.pp.count", 32'(count_o), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      step("ovf.drain", 3'b000, 0, 7'h0, 7'h0, 7'h0, 7'h0, 0, 1);

    // 5. Mid-operation reset
    do_reset();
    for (int i = 0; i < 3; i++)
      step("mr.fill", 3'b101, 1, 7'(i + 3), 7'h0, 7'h0, 7'h0, 0, 0);
    step("mr.lo", 3'b110, 1, 7'h09, 7'h09, 7'h09, 7'h09, 0, 0);
    do_reset();
    check_all("mr.reset");
    step("mr.fresh", 3'b110, 1, 7'h01, 7'h02, 7'h03, 7'h04, 0, 0);
    step("mr.flush", 3'b110, 0, 7'h0, 7'h0, 7'h0, 7'h0, 1, 0);
    check("mr.word", rd_data_o, 32'h0000_4321);
    do_reset();

    // 6. Idle mode ignored, pop on empty
    step("idle", 3'b000, 1, 7'h11, 7'h22, 7'h33, 7'h44, 0, 1);
    step("idle7", 3'b111, 1, 7'h11, 7'h22, 7'h33, 7'h44, 1, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0] md;
      case ($urandom_range(0, 3))
        0: md = 3'b101;
        1, 2: md = 3'b110;
        default: md = 3'($urandom_range(0, 7));
      endcase
      step("rnd", md, bit'($urandom_range(0, 1)), 7'($urandom), 7'($urandom),
           7'($urandom), 7'($urandom), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
